// File: rtl/pulse_gen_pkg.sv
// Shared types and constants for the NMR transmit H-bridge pulse generator.
package pulse_gen_pkg;

  localparam int unsigned DefHalfW = 16;
  localparam int unsigned DefCntW  = 16;

  // Register-bus select codes
  localparam logic [3:0] SelHalf = 4'd0;
  localparam logic [3:0] SelDead = 4'd1;
  localparam logic [3:0] SelNum  = 4'd2;

  localparam int unsigned RstHalf = 40;
  localparam int unsigned RstDead = 4;
  localparam int unsigned RstNum  = 8;
  localparam int unsigned HalfMin = 2;

  typedef enum logic [2:0] {
    StIdle,
    StActA,
    StDeadA,
    StActB,
    StDeadB,
    StDone
  } pg_state_e;

endpackage

// File: rtl/pulse_bridge_gen_if.sv
// Config bus, burst control and bridge drive signals of the pulse generator.
interface pulse_bridge_gen_if;

  logic        load;
  logic [3:0]  loadchoice;
  logic [15:0] datain;
  logic        pluse_start;
  logic        bri_cycle;
  logic        soft_dump;
  logic        bri_p;
  logic        bri_n;
  logic        pulse_busy;
  logic        pulse_done;

  modport master (
    output load, loadchoice, datain, pluse_start, bri_cycle, soft_dump,
    input  bri_p, bri_n, pulse_busy, pulse_done
  );

  modport slave (
    input  load, loadchoice, datain, pluse_start, bri_cycle, soft_dump,
    output bri_p, bri_n, pulse_busy, pulse_done
  );

endinterface

// File: rtl/pulse_bridge_gen.sv
// Burst generator for the two legs of the transmit H-bridge: programmable half-period,
// dead time and cycle count, latched per burst, with immediate abort on soft_dump.
module pulse_bridge_gen
  import pulse_gen_pkg::*;
#(
  parameter int unsigned HALF_W = DefHalfW,
  parameter int unsigned CNT_W  = DefCntW
) (
  input  logic               clk_sys,
  input  logic               rst_n,
  pulse_bridge_gen_if.slave  bus
);

  logic [HALF_W-1:0] half_q, half_d, dead_q, dead_d;
  logic [CNT_W-1:0]  num_q, num_d;
  logic [HALF_W-1:0] half_use, dead_use;
  logic [HALF_W-1:0] sh_half_q, sh_half_d, sh_dead_q, sh_dead_d;
  logic [CNT_W-1:0]  sh_num_q, sh_num_d;
  logic              sh_pol_q, sh_pol_d;
  logic [HALF_W-1:0] phase_q, phase_d, act_len;
  logic [CNT_W-1:0]  cyc_q, cyc_d, cyc_inc;
  logic              start_q, start_det;
  logic              last_act, last_dead, cyc_end;
  pg_state_e         state_q, state_d;
  logic              bri_p_q, bri_p_d, bri_n_q, bri_n_d;
  logic              busy_q, busy_d, done_q, done_d;

  always_comb begin
    half_d = half_q;
    dead_d = dead_q;
    num_d  = num_q;
    if (bus.load) begin
      case (bus.loadchoice)
        SelHalf: half_d = bus.datain[HALF_W-1:0];
        SelDead: dead_d = bus.datain[HALF_W-1:0];
        SelNum:  num_d  = bus.datain[CNT_W-1:0];
        default: ;
      endcase
    end
  end

  // Sanitised values presented to the shadows at burst start.
  always_comb begin
    half_use = (half_q < HALF_W'(HalfMin)) ? HALF_W'(HalfMin) : half_q;
    dead_use = (dead_q >= half_use) ? half_use - HALF_W'(1) : dead_q;
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      half_q  <= HALF_W'(RstHalf);
      dead_q  <= HALF_W'(RstDead);
      num_q   <= CNT_W'(RstNum);
      start_q <= 1'b0;
    end else begin
      half_q  <= half_d;
      dead_q  <= dead_d;
      num_q   <= num_d;
      start_q <= bus.pluse_start;
    end
  end

  assign start_det = bus.pluse_start & ~start_q;
  assign act_len   = sh_half_q - sh_dead_q;
  assign last_act  = (phase_q == act_len - HALF_W'(1));
  assign last_dead = (phase_q == sh_dead_q - HALF_W'(1));
  assign cyc_inc   = cyc_q + CNT_W'(1);

  // State register plus shadows, counters and registered outputs.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      sh_half_q <= HALF_W'(RstHalf);
      sh_dead_q <= HALF_W'(RstDead);
      sh_num_q  <= CNT_W'(RstNum);
      sh_pol_q  <= 1'b0;
      phase_q   <= '0;
      cyc_q     <= '0;
      bri_p_q   <= 1'b0;
      bri_n_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sh_half_q <= sh_half_d;
      sh_dead_q <= sh_dead_d;
      sh_num_q  <= sh_num_d;
      sh_pol_q  <= sh_pol_d;
      phase_q   <= phase_d;
      cyc_q     <= cyc_d;
      bri_p_q   <= bri_p_d;
      bri_n_q   <= bri_n_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    cyc_d     = cyc_q;
    sh_half_d = sh_half_q;
    sh_dead_d = sh_dead_q;
    sh_num_d  = sh_num_q;
    sh_pol_d  = sh_pol_q;
    cyc_end   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_det && !bus.soft_dump) begin
          sh_half_d = half_use;
          sh_dead_d = dead_use;
          sh_num_d  = num_q;
          sh_pol_d  = bus.bri_cycle;
          phase_d   = '0;
          cyc_d     = '0;
          state_d   = (num_q == '0) ? StDone : StActA;
        end
      end
      StActA: begin
        if (last_act) begin
          phase_d = '0;
          state_d = (sh_dead_q == '0) ? StActB : StDeadA;
        end else begin
          phase_d = phase_q + HALF_W'(1);
        end
      end
      StDeadA: begin
        if (last_dead) begin
          phase_d = '0;
          state_d = StActB;
        end else begin
          phase_d = phase_q + HALF_W'(1);
        end
      end
      StActB: begin
        if (last_act) begin
          phase_d = '0;
          if (sh_dead_q == '0) cyc_end = 1'b1;
          else                 state_d = StDeadB;
        end else begin
          phase_d = phase_q + HALF_W'(1);
        end
      end
      StDeadB: begin
        if (last_dead) cyc_end = 1'b1;
        else           phase_d = phase_q + HALF_W'(1);
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (cyc_end) begin
      cyc_d   = cyc_inc;
      phase_d = '0;
      state_d = (cyc_inc == sh_num_q) ? StDone : StActA;
    end
    if (bus.soft_dump && state_q != StIdle) state_d = StIdle;
  end

  // Outputs are decoded from the next state so they register in step with it.
  always_comb begin
    bri_p_d = sh_pol_d ? (state_d == StActB) : (state_d == StActA);
    bri_n_d = sh_pol_d ? (state_d == StActA) : (state_d == StActB);
    busy_d  = (state_d == StActA) || (state_d == StDeadA) ||
              (state_d == StActB) || (state_d == StDeadB);
    done_d  = (state_d == StDone);
  end

  assign bus.bri_p      = bri_p_q;
  assign bus.bri_n      = bri_n_q;
  assign bus.pulse_busy = busy_q;
  assign bus.pulse_done = done_q;

endmodule

// File: tb/tb_pulse_bridge_gen.sv
// Scoreboard bench: each start pushes the expected per-cycle {p,n,busy,done} trace;
// a monitor pops one entry per clock and expects all-zero outputs when the queue is empty.
module tb_pulse_bridge_gen;

  logic clk_sys = 1'b0;
  logic rst_n   = 1'b0;
  logic mon_en  = 1'b0;
  int   n_cmp   = 0;
  int   n_fail  = 0;
  logic [3:0] exp_q[$];
  logic [3:0] mon_got, mon_exp;

  pulse_bridge_gen_if bus ();

  pulse_bridge_gen #(.HALF_W(16), .CNT_W(16)) dut (
    .clk_sys (clk_sys),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  always #5 clk_sys = ~clk_sys;

  always @(posedge clk_sys) begin
    #1;
    if (mon_en) begin
      mon_got = {bus.bri_p, bus.bri_n, bus.pulse_busy, bus.pulse_done};
      mon_exp = (exp_q.size() > 0) ? exp_q.pop_front() : 4'b0000;
      n_cmp++;
      if (mon_got !== mon_exp) begin
        n_fail++;
        $display("FAIL trace @%0t: got {p,n,busy,done}=%b required %b", $time, mon_got, mon_exp);
      end
    end
  end

  task automatic check1(input string name, input logic got, input logic want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %b required %b", name, got, want);
    end
  endtask

  // Hand-computed act/dead lengths; cut >= 0 truncates the trace (abort).
  task automatic push_trace(input int act, input int dead, input int num, input bit pol,
                            input int cut);
    logic [3:0] a_ent, b_ent;
    int cnt = 0;
    a_ent = pol ? 4'b0110 : 4'b1010;
    b_ent = pol ? 4'b1010 : 4'b0110;
    for (int c = 0; c < num; c++) begin
      for (int i = 0; i < act; i++)  begin if (cut < 0 || cnt < cut) exp_q.push_back(a_ent); cnt++; end
      for (int i = 0; i < dead; i++) begin if (cut < 0 || cnt < cut) exp_q.push_back(4'b0010); cnt++; end
      for (int i = 0; i < act; i++)  begin if (cut < 0 || cnt < cut) exp_q.push_back(b_ent); cnt++; end
      for (int i = 0; i < dead; i++) begin if (cut < 0 || cnt < cut) exp_q.push_back(4'b0010); cnt++; end
    end
    if (cut < 0) exp_q.push_back(4'b0001);
  endtask

  task automatic write_reg(input logic [3:0] sel, input logic [15:0] val);
    @(negedge clk_sys);
    bus.load = 1'b1; bus.loadchoice = sel; bus.datain = val;
    @(negedge clk_sys);
    bus.load = 1'b0;
  endtask

  task automatic start_burst(input bit pol, input int act, input int dead, input int num,
                             input int cut);
    @(negedge clk_sys);
    bus.bri_cycle = pol; bus.pluse_start = 1'b1;
    push_trace(act, dead, num, pol, cut);
    @(negedge clk_sys);
    bus.pluse_start = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int k = 0;
    while (exp_q.size() != 0 && k < 2000) begin
      @(posedge clk_sys); k++;
    end
    repeat (3) @(negedge clk_sys);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s drain: got %0d entries left required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    bus.load = 1'b0; bus.loadchoice = 4'd0; bus.datain = 16'd0;
    bus.pluse_start = 1'b0; bus.bri_cycle = 1'b0; bus.soft_dump = 1'b0;
    #12;
    check1("reset bri_p", bus.bri_p, 1'b0);
    check1("reset bri_n", bus.bri_n, 1'b0);
    check1("reset busy", bus.pulse_busy, 1'b0);
    check1("reset done", bus.pulse_done, 1'b0);
    @(negedge clk_sys);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Reset defaults: half 40, dead 4, num 8
    start_burst(1'b0, 36, 4, 8, -1);
    wait_drain("defaults");

    // Nominal, with a second start edge and a half write mid-burst
    write_reg(4'd0, 16'd10);
    write_reg(4'd1, 16'd2);
    write_reg(4'd2, 16'd3);
    start_burst(1'b0, 8, 2, 3, -1);
    repeat (10) @(negedge clk_sys);
    bus.pluse_start = 1'b1;
    @(negedge clk_sys);
    bus.pluse_start = 1'b0;
    write_reg(4'd0, 16'd20);
    write_reg(4'd7, 16'd1);
    wait_drain("nominal");
    start_burst(1'b0, 18, 2, 3, -1);
    wait_drain("half20");

    // Abort at edge k+5, blocked start while dumping, then a clean full burst
    write_reg(4'd0, 16'd10);
    start_burst(1'b0, 8, 2, 3, 5);
    repeat (4) @(negedge clk_sys);
    bus.soft_dump = 1'b1;
    @(negedge clk_sys);
    bus.pluse_start = 1'b1;
    repeat (3) @(negedge clk_sys);
    bus.pluse_start = 1'b0;
    bus.soft_dump = 1'b0;
    @(negedge clk_sys);
    start_burst(1'b0, 8, 2, 3, -1);
    wait_drain("abort");

    // Inverted polarity, no dead time
    write_reg(4'd0, 16'd4);
    write_reg(4'd1, 16'd0);
    write_reg(4'd2, 16'd1);
    start_burst(1'b1, 4, 0, 1, -1);
    wait_drain("inverted");

    // Clamping: half 1 -> 2, dead 5 -> 1
    write_reg(4'd0, 16'd1);
    write_reg(4'd1, 16'd5);
    write_reg(4'd2, 16'd2);
    start_burst(1'b0, 1, 1, 2, -1);
    wait_drain("clamp");

    // Zero cycles: done only
    write_reg(4'd2, 16'd0);
    start_burst(1'b0, 0, 0, 0, -1);
    wait_drain("num0");

    // Write on the start edge: old half (6) is latched
    write_reg(4'd0, 16'd6);
    write_reg(4'd1, 16'd1);
    write_reg(4'd2, 16'd1);
    @(negedge clk_sys);
    bus.load = 1'b1; bus.loadchoice = 4'd0; bus.datain = 16'd2;
    bus.bri_cycle = 1'b0; bus.pluse_start = 1'b1;
    push_trace(5, 1, 1, 1'b0, -1);
    @(negedge clk_sys);
    bus.load = 1'b0; bus.pluse_start = 1'b0;
    wait_drain("load_at_start");

    // Asynchronous reset mid-burst
    write_reg(4'd0, 16'd10);
    write_reg(4'd2, 16'd3);
    start_burst(1'b0, 8, 1, 3, -1);
    repeat (3) @(negedge clk_sys);
    mon_en = 1'b0;
    rst_n  = 1'b0;
    exp_q.delete();
    #1;
    check1("async reset bri_p", bus.bri_p, 1'b0);
    check1("async reset busy", bus.pulse_busy, 1'b0);
    repeat (2) @(negedge clk_sys);
    rst_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pulse_bridge_gen.md
# pulse_bridge_gen

Transmit-pulse generator downstream of the 1 ms state sequencer. On each rising edge of `pluse_start` it drives the two legs of the NMR transmit H-bridge. Each burst is a programmable number of full bridge cycles, with a programmable half-period and dead time between the legs. Configuration uses the same `load`/`loadchoice`/`datain` register bus as the sequencer. `soft_dump` aborts a burst immediately.

## Interface
- `HALF_W`, 16: width of the half-period and dead-time registers.
- `CNT_W`, 16: width of the cycle-count register.
- `clk_sys`  in  1  system clock; all logic is on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `load`  in  1  write strobe, one cycle; data is written when `load`=1.
- `loadchoice`  in  4  register select: 0 = half_period, 1 = dead_time, 2 = num_cycles; all other codes are ignored.
- `datain`  in  16  write data; the low `HALF_W`/`CNT_W` bits are used.
- `pluse_start`  in  1  burst request, level from the sequencer; only its rising edge is used.
- `bri_cycle`  in  1  start polarity: 0 = positive leg first, 1 = negative leg first.
- `soft_dump`  in  1  abort request, level-sensitive.
- `bri_p`  out  1  positive-leg drive, registered.
- `bri_n`  out  1  negative-leg drive, registered.
- `pulse_busy`  out  1  high while a burst is running.
- `pulse_done`  out  1  one-cycle strobe when a burst completes normally.

## Operation
- **Config registers.** Reset values: half_period = 40, dead_time = 4, num_cycles = 8. A write takes effect on the clock edge where `load`=1. Writes are accepted at any time.
- **Shadow copies.** On burst start, shadow copies of the config registers are latched. A write during a burst does not affect that burst.
- **Sanitising at latch.**
  - half_period < 2 is used as 2.
  - dead_time ≥ half_period is used as half_period − 1.
  - dead_time = 0 is legal: the active phase passes directly to the opposite leg.
- **Start detection.** `pluse_start` is registered once. Start = current 1 AND previous 0. A start is honoured only in IDLE; starts during BUSY or DONE are dropped.
- **FSM states:** IDLE, ACT_A, DEAD_A, ACT_B, DEAD_B, DONE.
  - IDLE → ACT_A on start when num_cycles ≠ 0.
  - IDLE → DONE on start when num_cycles = 0.
  - ACT_A lasts (half − dead) clocks, then DEAD_A (dead clocks, skipped if 0), then ACT_B, then DEAD_B.
  - After DEAD_B, the cycle counter increments. If count = num_cycles the FSM goes to DONE, otherwise back to ACT_A.
  - DONE lasts one cycle, then IDLE.
- **Leg mapping.** Leg A = `bri_p` when the latched `bri_cycle`=0, else `bri_n`; leg B is the other leg. `bri_cycle` is latched together with the config shadows at start.
- **Outputs per state.** Outputs are 0 in DEAD, IDLE and DONE. `bri_p` and `bri_n` are never 1 in the same cycle.
- **Abort.** `soft_dump`=1 in any non-IDLE state forces IDLE on the next edge: both legs 0, `pulse_busy` 0, no `pulse_done`. `soft_dump` held high blocks new starts.
- **Counters.** Phase counter is `HALF_W` bits wide, cycle counter `CNT_W` bits; neither wraps inside a legal burst. One full bridge cycle = 2 × half clocks. A burst lasts 2 × half × num_cycles clocks.

## Timing
- **Reset:** `bri_p`=0, `bri_n`=0, `pulse_busy`=0, `pulse_done`=0, FSM in IDLE, config at defaults, edge register 0.
- **Start latency.** Let k be the edge where the start is detected. The first active leg goes high in cycle k+1; `pulse_busy` goes high in cycle k+1.
- **End of burst.** `pulse_busy` drops and `pulse_done` pulses in the cycle after the last DEAD_B cycle. For the num_cycles = 0 case, `pulse_done` pulses in cycle k+1 with `pulse_busy` never asserted.
- **Abort latency.** `soft_dump` sampled high at edge j gives all outputs 0 from cycle j+1.
- **Reset mid-burst:** all outputs go to 0 immediately (asynchronously).
- **Simultaneous events:**
  - `load` at the same edge as start: the old value is latched into the shadows.
  - `soft_dump` at the same edge as start: no burst.

## Structure
- **Package `pulse_gen_pkg`:** loadchoice codes, FSM state enum, reset defaults, `HALF_W`/`CNT_W` defaults.
- **Single module.** Counters and the edge detector are inline; no sub-module is warranted.

## Test plan
- **Nominal burst.** half=10, dead=2, num=3, bri_cycle=0, start at edge k → `bri_p` high k+1..k+8, both low k+9..k+10, `bri_n` high k+11..k+18; pattern repeats 3 times; `pulse_busy` high k+1..k+60; `pulse_done` in k+61.
- **Inverted polarity, no dead time.** bri_cycle=1, dead=0, half=4, num=1 → `bri_n` high k+1..k+4, `bri_p` high k+5..k+8, `pulse_done` in k+9.
- **Clamping.** half=1, dead=5, num=2 → latched as half=2, dead=1; each leg is active 1 clock with 1 dead clock; `pulse_done` in k+9.
- **Abort.** `soft_dump` raised at edge k+5 of the nominal burst → both legs 0 and busy 0 from k+6; no `pulse_done`; a new start after `soft_dump` drops runs a full burst.
- **Protocol edges.**
  - A second `pluse_start` edge mid-burst is ignored.
  - A `load` of half=20 mid-burst does not change the current burst, but the next burst uses 20.
  - num=0 → single `pulse_done` in k+1, legs never high.
